// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow asynchronous square wave in clk cycles
module period_meter #(
    parameter int              CNT_W       = 32,
    parameter int              SYNC_STAGES = 2,
    parameter longint unsigned TIMEOUT     = 200_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout,
    output logic [3:0]       edge_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hi_lat;
    logic [1:0]             state;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d  <= s;
        end
    end

    // cnt saturates at TMO so a dead input can never wrap into a bogus period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            hi_lat <= '0;
        end else begin
            if (rise) begin
                cnt <= ONE;
            end else if (cnt < TMO) begin
                cnt <= cnt + ONE;
            end
            if (fall) begin
                hi_lat <= cnt;
            end
        end
    end

    // a rise always wins over a timeout landing on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
            edge_cnt  <= 4'd0;
        end else begin
            valid <= 1'b0;
            if (rise) begin
                edge_cnt <= edge_cnt + 4'd1;
                timeout  <= 1'b0;
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end
                    ARMED, LOCKED: begin
                        period    <= cnt;
                        high_time <= hi_lat;
                        valid     <= 1'b1;
                        locked    <= 1'b1;
                        state     <= LOCKED;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE && cnt == TMO) begin
                state   <= IDLE;
                timeout <= 1'b1;
                locked  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter
module tb_period_meter;

    localparam int TMO = 1000;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        valid;
    logic        locked;
    logic        timeout;
    logic [3:0]  edge_cnt;

    period_meter #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout),
        .edge_cnt  (edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fails;
    logic [63:0] sb_q[$];
    logic [63:0] sb_item;
    bit          have_prev;
    int          prev_p;
    int          prev_h;
    int          last_p;
    int          last_h;
    int          ec_model;
    bit          lenient;
    bit          skip_step;
    logic [3:0]  prev_ec;
    logic        prev_valid;
    logic [3:0]  ec_diff;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_zero();
        check("rst_period", period, 32'd0);
        check("rst_high_time", high_time, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    endtask

    task automatic model_reset();
        have_prev = 1'b0;
        ec_model  = 0;
        sb_q.delete();
        skip_step = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero();
        model_reset();
    endtask

    // one rise-to-rise cycle of sig_in; optional mid-cycle reset or 1-cycle glitch
    task automatic drive_cycle(input int p, input int h, input int rst_at, input int glitch_at);
        int ec_old;
        bit had;
        bit was_rst;
        had     = have_prev;
        was_rst = 1'b0;
        if (had) begin
            sb_q.push_back({32'(prev_p), 32'(prev_h)});
            last_p = prev_p;
            last_h = prev_h;
        end
        ec_old   = ec_model;
        ec_model = (ec_model + 1) % 16;
        sig_in   = 1'b1;
        for (int k = 1; k <= p; k++) begin
            @(posedge clk);
            #1;
            if (!lenient && !was_rst) begin
                if (k == 2) begin
                    check("ec_before_rise", 32'(edge_cnt), 32'(ec_old));
                    check("valid_latency", 32'(valid), 32'd0);
                end
                if (k == 3) begin
                    check("ec_after_rise", 32'(edge_cnt), 32'(ec_model));
                    check("timeout_clear", 32'(timeout), 32'd0);
                    check("locked_state", 32'(locked), 32'(had));
                end
                if (p > TMO + 3 && k == TMO + 2) begin
                    check("timeout_early", 32'(timeout), 32'd0);
                end
                if (p > TMO + 3 && k == TMO + 3) begin
                    check("timeout_set", 32'(timeout), 32'd1);
                    check("timeout_unlock", 32'(locked), 32'd0);
                    check("timeout_period_hold", period, 32'(last_p));
                    check("timeout_high_hold", high_time, 32'(last_h));
                end
            end
            if (k == h) sig_in = 1'b0;
            if (glitch_at != 0 && k == glitch_at) sig_in = 1'b1;
            if (glitch_at != 0 && k == glitch_at + 1) sig_in = 1'b0;
            if (rst_at != 0 && k == rst_at) rst = 1'b1;
            if (rst_at != 0 && k == rst_at + 1) begin
                rst     = 1'b0;
                was_rst = 1'b1;
                check_zero();
                model_reset();
            end
        end
        if (!was_rst) begin
            have_prev = (p <= TMO);
            prev_p    = p;
            prev_h    = h;
        end
    endtask

    always @(negedge clk) begin
        if (skip_step) begin
            skip_step = 1'b0;
        end else begin
            if (edge_cnt !== prev_ec) begin
                ec_diff = edge_cnt - prev_ec;
                check("ec_step", 32'(ec_diff), 32'd1);
            end
            if (valid) begin
                check("valid_width", 32'(prev_valid), 32'd0);
                if (lenient) begin
                    check("valid_known", 32'($isunknown({period, high_time})), 32'd0);
                end else if (sb_q.size() == 0) begin
                    check("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_item = sb_q.pop_front();
                    check("period", period, sb_item[63:32]);
                    check("high_time", high_time, sb_item[31:0]);
                    check("locked_on_valid", 32'(locked), 32'd1);
                end
            end
        end
        prev_ec    = edge_cnt;
        prev_valid = valid;
    end

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b1;
        sig_in     = 1'b0;
        lenient    = 1'b0;
        skip_step  = 1'b1;
        have_prev  = 1'b0;
        ec_model   = 0;
        prev_p     = 0;
        prev_h     = 0;
        last_p     = 0;
        last_h     = 0;
        prev_ec    = 4'd0;
        prev_valid = 1'b0;
        do_reset();

        repeat (5) drive_cycle(100, 30, 0, 0);

        repeat (2) drive_cycle(100, 70, 0, 0);
        repeat (2) drive_cycle(250, 125, 0, 0);
        drive_cycle(100, 30, 0, 0);

        drive_cycle(1200, 30, 0, 0);
        drive_cycle(100, 30, 0, 0);
        drive_cycle(TMO, 40, 0, 0);
        repeat (2) drive_cycle(100, 30, 0, 0);

        do_reset();
        repeat (17) drive_cycle(20, 8, 0, 0);

        do_reset();
        repeat (2) drive_cycle(100, 30, 0, 0);
        drive_cycle(100, 30, 40, 0);
        repeat (3) drive_cycle(100, 30, 0, 0);

        do_reset();
        lenient = 1'b1;
        drive_cycle(100, 30, 0, 0);
        drive_cycle(100, 30, 0, 60);
        repeat (2) drive_cycle(100, 30, 0, 0);
        lenient = 1'b0;
        do_reset();
        repeat (3) drive_cycle(100, 30, 0, 0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
